// File: rtl/execute_stage.sv
// execute_stage: execute stage of the five-stage Y86-64 pipeline.
// Computes the ALU result, updates the {ZF,SF,OF} condition codes and evaluates
// branch/cmov conditions. Holds the M pipeline register feeding the memory stage.
//
// Ports:
//   clk, rst_n             clock (rising edge) and asynchronous active-low reset
//   E_stat .. E_dstM       decode-stage E register contents
//   m_stat, W_stat         downstream status, gates condition-code updates
//   M_bubble               load a bubble into the M register this edge
//   e_valE, e_dstE, e_cnd  combinational results for forwarding / mispredict
//   cc                     condition-code register {ZF,SF,OF}
//   M_*                    M pipeline register outputs
module execute_stage #(
    parameter logic [3:0] STAT_AOK = 4'd1,
    parameter logic [3:0] RNONE    = 4'hF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  E_stat,
    input  logic [3:0]  E_icode,
    input  logic [3:0]  E_ifun,
    input  logic [63:0] E_valC,
    input  logic [63:0] E_valA,
    input  logic [63:0] E_valB,
    input  logic [3:0]  E_dstE,
    input  logic [3:0]  E_dstM,
    input  logic [3:0]  m_stat,
    input  logic [3:0]  W_stat,
    input  logic        M_bubble,
    output logic [63:0] e_valE,
    output logic [3:0]  e_dstE,
    output logic        e_cnd,
    output logic [2:0]  cc,
    output logic [3:0]  M_stat,
    output logic [3:0]  M_icode,
    output logic        M_cnd,
    output logic [63:0] M_valE,
    output logic [63:0] M_valA,
    output logic [3:0]  M_dstE,
    output logic [3:0]  M_dstM
);

    localparam logic [3:0] I_CMOV  = 4'h2;
    localparam logic [3:0] I_OPQ   = 4'h6;
    localparam logic [3:0] I_NOP   = 4'h1;

    logic [63:0] w_alu_a;
    logic [63:0] w_alu_b;
    logic [3:0]  w_alu_fun;
    logic [63:0] w_result;
    logic        w_zf;
    logic        w_sf;
    logic        w_of;
    logic        w_set_cc;
    logic        w_cnd;
    logic        w_lt;

    logic [2:0]  r_cc;
    logic [3:0]  r_stat;
    logic [3:0]  r_icode;
    logic        r_cnd;
    logic [63:0] r_val_e;
    logic [63:0] r_val_a;
    logic [3:0]  r_dst_e;
    logic [3:0]  r_dst_m;

    // ALU operand selection by instruction class.
    always_comb begin
        w_alu_a = 64'd0;
        unique case (E_icode)
            4'h2, 4'h6:       w_alu_a = E_valA;
            4'h3, 4'h4, 4'h5: w_alu_a = E_valC;
            4'h8, 4'hA:       w_alu_a = 64'hFFFF_FFFF_FFFF_FFF8; // -8: call/push
            4'h9, 4'hB:       w_alu_a = 64'd8;                   // +8: ret/pop
            default:          w_alu_a = 64'd0;
        endcase
    end

    always_comb begin
        w_alu_b = 64'd0;
        unique case (E_icode)
            4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB: w_alu_b = E_valB;
            default:                                   w_alu_b = 64'd0;
        endcase
    end

    assign w_alu_fun = (E_icode == I_OPQ) ? E_ifun : 4'h0;

    always_comb begin
        w_result = 64'd0;
        w_of     = 1'b0;
        unique case (w_alu_fun)
            4'h0: begin
                w_result = w_alu_b + w_alu_a;
                w_of     = (w_alu_a[63] == w_alu_b[63]) && (w_result[63] != w_alu_a[63]);
            end
            4'h1: begin
                w_result = w_alu_b - w_alu_a;
                w_of     = (w_alu_a[63] != w_alu_b[63]) && (w_result[63] != w_alu_b[63]);
            end
            4'h2:    w_result = w_alu_b & w_alu_a;
            4'h3:    w_result = w_alu_b ^ w_alu_a;
            default: w_result = 64'd0;
        endcase
    end

    assign w_zf     = (w_result == 64'd0);
    assign w_sf     = w_result[63];
    assign w_set_cc = (E_icode == I_OPQ) && (m_stat == STAT_AOK) && (W_stat == STAT_AOK);

    // Condition evaluated from the registered flags only, never this cycle's result.
    assign w_lt = r_cc[1] ^ r_cc[0];

    always_comb begin
        w_cnd = 1'b0;
        unique case (E_ifun)
            4'h0:    w_cnd = 1'b1;
            4'h1:    w_cnd = w_lt | r_cc[2];
            4'h2:    w_cnd = w_lt;
            4'h3:    w_cnd = r_cc[2];
            4'h4:    w_cnd = ~r_cc[2];
            4'h5:    w_cnd = ~w_lt;
            4'h6:    w_cnd = ~w_lt & ~r_cc[2];
            default: w_cnd = 1'b0;
        endcase
    end

    assign e_valE = w_result;
    assign e_cnd  = w_cnd;
    assign e_dstE = ((E_icode == I_CMOV) && !w_cnd) ? RNONE : E_dstE;

    // Condition codes: updated on set_cc independent of M_bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cc <= 3'b100;
        end else if (w_set_cc) begin
            r_cc <= {w_zf, w_sf, w_of};
        end
    end

    // M pipeline register; reset and bubble both load a nop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat  <= STAT_AOK;
            r_icode <= I_NOP;
            r_cnd   <= 1'b0;
            r_val_e <= 64'd0;
            r_val_a <= 64'd0;
            r_dst_e <= RNONE;
            r_dst_m <= RNONE;
        end else if (M_bubble) begin
            r_stat  <= STAT_AOK;
            r_icode <= I_NOP;
            r_cnd   <= 1'b0;
            r_val_e <= 64'd0;
            r_val_a <= 64'd0;
            r_dst_e <= RNONE;
            r_dst_m <= RNONE;
        end else begin
            r_stat  <= E_stat;
            r_icode <= E_icode;
            r_cnd   <= w_cnd;
            r_val_e <= w_result;
            r_val_a <= E_valA;
            r_dst_e <= e_dstE;
            r_dst_m <= E_dstM;
        end
    end

    assign cc      = r_cc;
    assign M_stat  = r_stat;
    assign M_icode = r_icode;
    assign M_cnd   = r_cnd;
    assign M_valE  = r_val_e;
    assign M_valA  = r_val_a;
    assign M_dstE  = r_dst_e;
    assign M_dstM  = r_dst_m;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed test-plan steps followed by
// randomized instructions, compared against an instruction-level reference model.
module tb_execute_stage;

    localparam logic [3:0] AOK   = 4'd1;
    localparam logic [3:0] RNONE = 4'hF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  E_stat, E_icode, E_ifun, E_dstE, E_dstM, m_stat, W_stat;
    logic [63:0] E_valC, E_valA, E_valB;
    logic        M_bubble;
    logic [63:0] e_valE, M_valE, M_valA;
    logic [3:0]  e_dstE, M_stat, M_icode, M_dstE, M_dstM;
    logic        e_cnd, M_cnd;
    logic [2:0]  cc;

    execute_stage #(.STAT_AOK(AOK), .RNONE(RNONE)) dut (
        .clk(clk), .rst_n(rst_n),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
        .E_dstE(E_dstE), .E_dstM(E_dstM),
        .m_stat(m_stat), .W_stat(W_stat), .M_bubble(M_bubble),
        .e_valE(e_valE), .e_dstE(e_dstE), .e_cnd(e_cnd), .cc(cc),
        .M_stat(M_stat), .M_icode(M_icode), .M_cnd(M_cnd),
        .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    // Reference state: flags and the expected M register contents.
    logic        ref_zf, ref_sf, ref_of;
    logic [3:0]  rm_stat, rm_icode, rm_dstE, rm_dstM;
    logic        rm_cnd;
    logic [63:0] rm_valE, rm_valA;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Result of an OPq: b op a.
    function automatic logic [63:0] op_result(input logic [3:0] ifun, input logic [63:0] a,
                                              input logic [63:0] b);
        case (ifun)
            4'd0:    return b + a;
            4'd1:    return b - a;
            4'd2:    return b & a;
            4'd3:    return b ^ a;
            default: return 64'd0;
        endcase
    endfunction

    // Signed overflow: the exact 65-bit signed result does not fit in 64 bits.
    function automatic logic op_overflow(input logic [3:0] ifun, input logic [63:0] a,
                                         input logic [63:0] b);
        logic signed [64:0] wide;
        if (ifun == 4'd0) wide = $signed({b[63], b}) + $signed({a[63], a});
        else if (ifun == 4'd1) wide = $signed({b[63], b}) - $signed({a[63], a});
        else return 1'b0;
        return wide[64] != wide[63];
    endfunction

    // valE by instruction meaning.
    function automatic logic [63:0] ref_valE(input logic [3:0] icode, input logic [3:0] ifun,
                                             input logic [63:0] c, input logic [63:0] a,
                                             input logic [63:0] b);
        case (icode)
            4'h2:       return a;             // rrmovq / cmovXX
            4'h3:       return c;             // irmovq
            4'h4, 4'h5: return b + c;         // effective address
            4'h6:       return op_result(ifun, a, b);
            4'h8, 4'hA: return b - 64'd8;     // call / pushq
            4'h9, 4'hB: return b + 64'd8;     // ret / popq
            default:    return 64'd0;
        endcase
    endfunction

    function automatic logic ref_cond(input logic [3:0] ifun);
        logic lt;
        lt = ref_sf ^ ref_of;
        case (ifun)
            4'd0:    return 1'b1;
            4'd1:    return lt | ref_zf;
            4'd2:    return lt;
            4'd3:    return ref_zf;
            4'd4:    return !ref_zf;
            4'd5:    return !lt;
            4'd6:    return !lt && !ref_zf;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_bubble();
        rm_stat = AOK; rm_icode = 4'h1; rm_cnd = 1'b0;
        rm_valE = 64'd0; rm_valA = 64'd0; rm_dstE = RNONE; rm_dstM = RNONE;
    endtask

    task automatic model_reset();
        model_bubble();
        ref_zf = 1'b1; ref_sf = 1'b0; ref_of = 1'b0;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".cc"}, 64'(cc), 64'({ref_zf, ref_sf, ref_of}));
        check({tag, ".M_stat"}, 64'(M_stat), 64'(rm_stat));
        check({tag, ".M_icode"}, 64'(M_icode), 64'(rm_icode));
        check({tag, ".M_cnd"}, 64'(M_cnd), 64'(rm_cnd));
        check({tag, ".M_valE"}, M_valE, rm_valE);
        check({tag, ".M_valA"}, M_valA, rm_valA);
        check({tag, ".M_dstE"}, 64'(M_dstE), 64'(rm_dstE));
        check({tag, ".M_dstM"}, 64'(M_dstM), 64'(rm_dstM));
    endtask

    // One instruction: drive E, check combinational outputs, clock, check state.
    task automatic step(input string tag, input logic [3:0] stat, input logic [3:0] icode,
                        input logic [3:0] ifun, input logic [63:0] c, input logic [63:0] a,
                        input logic [63:0] b, input logic [3:0] dste, input logic [3:0] dstm,
                        input logic [3:0] ms, input logic [3:0] ws, input logic bub);
        logic [63:0] exp_val;
        logic        exp_cnd;
        logic [3:0]  exp_dst;
        E_stat = stat; E_icode = icode; E_ifun = ifun; E_valC = c; E_valA = a; E_valB = b;
        E_dstE = dste; E_dstM = dstm; m_stat = ms; W_stat = ws; M_bubble = bub;
        #1;
        exp_val = ref_valE(icode, ifun, c, a, b);
        exp_cnd = ref_cond(ifun);
        exp_dst = (icode == 4'h2 && !exp_cnd) ? RNONE : dste;
        check({tag, ".e_valE"}, e_valE, exp_val);
        check({tag, ".e_cnd"}, 64'(e_cnd), 64'(exp_cnd));
        check({tag, ".e_dstE"}, 64'(e_dstE), 64'(exp_dst));
        @(posedge clk);
        #1;
        if (icode == 4'h6 && ms == AOK && ws == AOK) begin
            ref_zf = (exp_val == 64'd0);
            ref_sf = exp_val[63];
            ref_of = op_overflow(ifun, a, b);
        end
        if (bub) model_bubble();
        else begin
            rm_stat = stat; rm_icode = icode; rm_cnd = exp_cnd; rm_valE = exp_val;
            rm_valA = a; rm_dstE = exp_dst; rm_dstM = dstm;
        end
        check_state(tag);
    endtask

    localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;

    initial begin
        logic [3:0]  r_icode, r_ifun, r_ms, r_ws, r_stat;
        logic [63:0] r_a, r_b, r_c;
        logic        r_bub;

        E_stat = AOK; E_icode = 4'h1; E_ifun = 4'h0; E_valC = '0; E_valA = '0; E_valB = '0;
        E_dstE = RNONE; E_dstM = RNONE; m_stat = AOK; W_stat = AOK; M_bubble = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #12;
        check_state("por");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Load something non-trivial, then assert reset mid-cycle.
        step("pre", 4'd3, 4'h6, 4'h0, 64'd0, 64'd7, 64'd9, 4'd2, 4'd5, AOK, AOK, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_state("async_rst");
        check("rst_icode_const", 64'(M_icode), 64'd1);
        check("rst_cc_const", 64'(cc), 64'(3'b100));
        @(posedge clk);
        #1;
        check_state("rst_held");
        #2;
        rst_n = 1'b1;

        step("sub", AOK, 4'h6, 4'h1, 64'd0, 64'd5, 64'd3, 4'd1, RNONE, AOK, AOK, 1'b0);
        check("sub_cc_const", 64'(cc), 64'(3'b010));
        check("sub_valE_const", M_valE, 64'hFFFF_FFFF_FFFF_FFFE);

        step("ovf", AOK, 4'h6, 4'h0, 64'd0, MAXP, MAXP, 4'd1, RNONE, AOK, AOK, 1'b0);
        check("ovf_cc_const", 64'(cc), 64'(3'b011));
        step("ovf_gated", AOK, 4'h6, 4'h1, 64'd0, 64'd4, 64'd4, 4'd1, RNONE, 4'd2, AOK, 1'b0);
        check("gated_cc_const", 64'(cc), 64'(3'b011));
        step("ovf_wgated", AOK, 4'h6, 4'h2, 64'd0, 64'd0, 64'd0, 4'd1, RNONE, AOK, 4'd3, 1'b0);

        step("set_zf", AOK, 4'h6, 4'h3, 64'd0, 64'd42, 64'd42, 4'd1, RNONE, AOK, AOK, 1'b0);
        step("cmovne_nt", AOK, 4'h2, 4'h4, 64'd0, 64'h55, 64'd0, 4'd3, RNONE, AOK, AOK, 1'b0);
        check("cmov_nt_dst_const", 64'(M_dstE), 64'd15);
        step("clr_zf", AOK, 4'h6, 4'h0, 64'd0, 64'd1, 64'd0, 4'd1, RNONE, AOK, AOK, 1'b0);
        step("cmovne_t", AOK, 4'h2, 4'h4, 64'd0, 64'h66, 64'd0, 4'd3, RNONE, AOK, AOK, 1'b0);
        check("cmov_t_dst_const", 64'(M_dstE), 64'd3);

        step("call", AOK, 4'h8, 4'h0, 64'h40, 64'd0, 64'h100, 4'd4, RNONE, AOK, AOK, 1'b0);
        check("call_valE_const", M_valE, 64'hF8);
        step("popq", AOK, 4'hB, 4'h0, 64'd0, 64'd0, 64'hF8, 4'd4, 4'd6, AOK, AOK, 1'b0);
        check("popq_valE_const", M_valE, 64'h100);

        step("bub_rm", AOK, 4'h4, 4'h0, 64'h10, 64'h77, 64'h200, RNONE, RNONE, AOK, AOK, 1'b1);
        step("bub_op", AOK, 4'h6, 4'h1, 64'd0, 64'd9, 64'd2, 4'd1, RNONE, AOK, AOK, 1'b1);
        step("jle_after", AOK, 4'h7, 4'h1, 64'h300, 64'd0, 64'd0, RNONE, RNONE, AOK, AOK, 1'b0);

        for (int i = 0; i < 300; i++) begin
            r_icode = 4'($urandom_range(0, 15));
            r_ifun  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(4, 15))
                                                  : 4'($urandom_range(0, 3));
            if (r_icode != 4'h6 && $urandom_range(0, 1) == 1) r_ifun = 4'($urandom_range(0, 7));
            r_a = {$urandom, $urandom};
            r_b = {$urandom, $urandom};
            r_c = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: r_b = r_a;
                1: begin r_a[63:62] = 2'b01; r_b[63:62] = 2'b01; end
                2: begin r_a[63] = 1'b1; r_b[63] = 1'b0; end
                default: ;
            endcase
            r_ms   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(2, 4)) : AOK;
            r_ws   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(2, 4)) : AOK;
            r_stat = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : AOK;
            r_bub  = ($urandom_range(0, 9) == 0);
            step($sformatf("rnd%0d", i), r_stat, r_icode, r_ifun, r_c, r_a, r_b,
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), r_ms, r_ws, r_bub);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the five-stage Y86-64 pipeline: takes the decode-stage E register contents, computes the ALU result, updates condition codes and evaluates branch/cmov conditions. It also holds the M pipeline register that feeds the memory stage. It publishes e_valE, e_dstE and e_cnd combinationally for forwarding and mispredict detection.

## Interface
Parameters:
- STAT_AOK, 4'd1, status code meaning "no exception"; any other value is an exception.
- RNONE, 4'hF, register ID meaning "no destination".

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- E_stat  in  4  instruction status.
- E_icode  in  4  instruction code.
- E_ifun  in  4  function code.
- E_valC  in  64  constant.
- E_valA  in  64  operand A.
- E_valB  in  64  operand B.
- E_dstE  in  4  destination register for valE.
- E_dstM  in  4  destination register for valM.
- m_stat  in  4  current memory-stage status, used for set_cc gating.
- W_stat  in  4  current writeback-stage status, used for set_cc gating.
- M_bubble  in  1  load a bubble into the M register this edge.
- e_valE  out  64  combinational ALU result.
- e_dstE  out  4  combinational effective dstE.
- e_cnd  out  1  combinational condition result.
- cc  out  3  {ZF,SF,OF} register.
- M_stat  out  4  M register output.
- M_icode  out  4  M register output.
- M_cnd  out  1  M register output.
- M_valE  out  64  M register output.
- M_valA  out  64  M register output.
- M_dstE  out  4  M register output.
- M_dstM  out  4  M register output.

## Operation
- **aluA selection:**
  - E_valA for icode 2 and 6.
  - E_valC for icode 3, 4 and 5.
  - -8 for icode 8 and A.
  - +8 for icode 9 and B.
  - 0 otherwise.
- **aluB selection:**
  - E_valB for icode 4, 5, 6, 8, 9, A and B.
  - 0 for icode 2 and 3, and otherwise.
- **ALU function:** E_ifun when icode==6, else add.
- **ALU operations** (64-bit, wrap modulo 2^64):
  - ifun 0: aluB+aluA.
  - ifun 1: aluB-aluA.
  - ifun 2: aluB&aluA.
  - ifun 3: aluB^aluA.
  - ifun ≥4 with icode 6: result 0.
- **Flags:**
  - ZF = (result==0).
  - SF = result[63].
  - OF on add = (aluA[63]==aluB[63]) && (result[63]!=aluA[63]).
  - OF on sub = (aluA[63]!=aluB[63]) && (result[63]!=aluB[63]).
  - OF = 0 for and/xor.
- **set_cc** = (E_icode==6) && m_stat==STAT_AOK && W_stat==STAT_AOK.
  - When set_cc is true, cc is loaded at the edge.
  - CC updates regardless of M_bubble.
- **e_cnd from the current cc (before any update this cycle):**
  - ifun 0: 1.
  - ifun 1 (le): (SF^OF)|ZF.
  - ifun 2 (l): SF^OF.
  - ifun 3 (e): ZF.
  - ifun 4 (ne): !ZF.
  - ifun 5 (ge): !(SF^OF).
  - ifun 6 (g): !(SF^OF)&!ZF.
  - ifun ≥7: 0.
  - Evaluated for all icodes; meaningful only for 2 and 7.
- **e_dstE:** RNONE when E_icode==2 && !e_cnd, else E_dstE.
- **M register load:** {E_stat, E_icode, e_cnd, e_valE, E_valA, e_dstE, E_dstM}.
- **Bubble value:** stat=STAT_AOK, icode=1 (nop), cnd=0, valE=0, valA=0, dstE=dstM=RNONE.

## Timing
- Combinational outputs settle within the cycle the E inputs are presented; zero latency.
- M register and cc update on posedge clk; E inputs appear at M outputs one cycle later.
- **Reset (rst_n low):** takes effect immediately and asynchronously, without waiting for a clock.
  - M register takes the bubble value.
  - cc = {ZF=1, SF=0, OF=0}.
  - Held while rst_n is low.
  - The first edge after deassertion loads normally.
- **Reset mid-instruction:** the in-flight M contents are discarded and the CC update is lost.
- **M_bubble:** overrides the normal load at that edge; cc still follows set_cc.
- **Same-edge conditional after OPq:** a conditional instruction in E in the cycle following an OPq sees the cc written at the intervening edge. e_cnd never uses same-cycle flags.

## Test plan
- **Reset:** assert rst_n=0 mid-cycle → M_icode=1, M_dstE=M_dstM=15 and cc=3'b100 immediately, before any clock edge.
- **Subtract:** OPq sub (icode 6, ifun 1), valA=5, valB=3 → e_valE=64'hFFFF_FFFF_FFFF_FFFE; after the edge cc={0,1,0} and M_valE equals that value.
- **Overflow:** OPq add, valA=valB=64'h7FFF_FFFF_FFFF_FFFF → e_valE=64'hFFFF_FFFF_FFFF_FFFE, cc={0,1,1}. Repeat with m_stat=2 → cc unchanged.
- **cmov not taken:** cmovne (icode 2, ifun 4) with ZF=1, E_dstE=3 → e_cnd=0, e_dstE=15, M_dstE=15. Repeat with ZF=0 → M_dstE=3, M_valE=valA.
- **Stack arithmetic:** call with valB=64'h100 → e_valE=64'hF8. popq with valB=64'hF8 → e_valE=64'h100. Neither changes cc.
- **Bubble:** M_bubble=1 on an edge carrying rmmovq → M holds the bubble value; an OPq in E on that edge still updates cc.
